// File: rtl/bit_ser_addsub.sv
// Bit-serial adder/subtractor with a start/busy/done handshake.
// Operands stream in LSB first on A and B, one bit per clock. Each sum bit
// is registered onto serial_result and also shifted into a parallel result
// word whose top bit carries the final carry (add) or borrow (sub). A signed
// overflow flag is computed from the carries into and out of the MSB.
module bit_ser_addsub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             sub,
  input  logic             A,
  input  logic             B,
  output logic             busy,
  output logic             done,
  output logic             serial_valid,
  output logic             serial_result,
  output logic [WIDTH:0]   result,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the edge that consumes the MSB of the operands.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             mode;       // latched operation: 0 = add, 1 = subtract
  logic             carry;      // carry into the bit currently on A/B
  logic [CNT_W-1:0] count;      // index of the bit currently on A/B

  logic             b_eff;
  logic             sum;
  logic             cout;
  logic             last_bit;

  // Full-adder slice: B is inverted for subtraction, and the carry register
  // is preloaded with 1 at acceptance, giving A + ~B + 1.
  always_comb begin
    b_eff    = B ^ mode;
    sum      = A ^ b_eff ^ carry;
    cout     = (A & b_eff) | (A & carry) | (b_eff & carry);
    last_bit = (count == LAST_BIT);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start only matters in IDLE, so it is ignored in RUN/DONE.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand latch at acceptance, one adder step per RUN edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      mode          <= 1'b0;
      carry         <= 1'b0;
      count         <= '0;
      result        <= '0;
      overflow      <= 1'b0;
      serial_result <= 1'b0;
      serial_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode     <= sub;
            carry    <= sub;
            count    <= '0;
            result   <= '0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          carry               <= cout;
          count               <= count + 1'b1;
          result[WIDTH-1:0]   <= {sum, result[WIDTH-1:1]};
          serial_result       <= sum;
          serial_valid        <= 1'b1;
          if (last_bit) begin
            // Carry-out for add; for subtract a missing carry means a borrow.
            result[WIDTH] <= cout ^ mode;
            // Signed overflow: carry into the MSB differs from carry out.
            overflow      <= carry ^ cout;
          end
        end
        DONE: begin
          // The last serial bit is visible alongside done; drop valid after.
          serial_valid <= 1'b0;
        end
        default: begin
          serial_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
